aemb_dwb_sram: RTL
==================

# aemb_dwb_sram

Wishbone data-bus responder for the AEMB core: a single-port, word-organised SRAM slave that answers the core's `dwb_stb_o`/`dwb_we_o` master strobes with a registered acknowledge after a configurable number of wait states. It sits on the far end of the core's data bus and is the memory the core's load/store stages talk to. Byte lanes are big-endian, matching the core's endian correction.

## Interface
- `AW`, 10: word-address width; capacity is 2^AW 32-bit words.
- `WAIT`, 1: wait states inserted before acknowledge. Legal range is 0..15.
- `nclk`, input, 1: clock. All state updates on the falling edge.
- `nrst`, input, 1: reset, asynchronous, active-high.
- `dwb_stb_i`, input, 1: transfer request. The master holds it until acknowledged.
- `dwb_we_i`, input, 1: 1 = write, 0 = read. Sampled with `stb`.
- `dwb_adr_i`, input, 32: byte address. Bits [1:0] are ignored.
- `dwb_sel_i`, input, 4: byte-lane enables for writes. `sel[3]` maps to `dat[31:24]` (lowest byte address).
- `dwb_dat_i`, input, 32: write data.
- `dwb_dat_o`, output, 32: read data. Valid only while `dwb_ack_o` is high.
- `dwb_ack_o`, output, 1: transfer complete. Single-cycle pulse.
- `dwb_err_o`, output, 1: out-of-range transfer terminated. Single-cycle pulse.

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- **IDLE**
  - If `stb` is high, capture `adr[AW+1:2]`, `we`, `sel` and `dat_i` into request registers.
  - Compute `range_err = |adr[31:AW+2]`.
  - Load the wait counter with `WAIT`.
  - Next state is RESP if `WAIT==0`, otherwise WAIT.
- **WAIT**
  - If `stb` drops, abort: go to IDLE with no write and no ack/err.
  - Otherwise decrement the counter. When the counter reaches 1, go to RESP.
- **RESP**
  - Entered only on the edge that leaves WAIT or IDLE. On that edge, the memory action happens:
    - Write, in range: each byte lane with `sel[i]=1` is written from the captured data. Lanes with `sel[i]=0` are preserved. `sel=4'b0000` writes nothing but is still acknowledged.
    - Read, in range: `dat_o` is loaded with the addressed word.
    - Out of range: no memory access, and `dat_o` stays 0.
  - In RESP, exactly one of `ack_o` or `err_o` is high for one cycle.
  - Unconditional next state is IDLE.
- `dat_o` returns to 0 on leaving RESP. Writes never change `dat_o` from 0.
- The memory array is not reset. Contents survive `nrst`.
- There is no back-to-back fast path. A `stb` held high after an ack starts a new transfer in the following IDLE cycle.

## Timing
- Reset values: `ack_o=0`, `err_o=0`, `dat_o=0`, state IDLE, counter 0, request registers 0.
- Latency from the edge where IDLE samples `stb=1` to the `ack_o` assertion is `WAIT+1` edges. With `WAIT=0`, ack is high in the cycle after the request is sampled.
- Minimum transfer period is `WAIT+2` cycles (one IDLE plus `WAIT` wait cycles plus one RESP).
- `ack_o`, `err_o` and `dat_o` are registered outputs with no combinational path from any input.
- Reset asserted mid-transfer: outputs drop to 0 immediately (asynchronously) and the state returns to IDLE.
  - A write whose commit edge has not yet occurred is lost.
  - A write already committed remains in memory.
- Counter wrap: the counter never decrements below 1. A `WAIT` value above 15 is a configuration error, flagged by an elaboration check.
- `we`, `sel`, `adr` and `dat_i` changing while in WAIT are ignored; the captured copies are used.

## Structure
- Package `aemb_wb_pkg`:
  - FSM state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - Byte-lane index constants: `LANE0_HI=31` … `LANE3_HI=7`.
  - Wait-counter width: 4.
- Sub-module `aemb_wb_sram_core`: the 2^AW×32 array with a 4-bit byte-write enable and a registered read port. The FSM, counter, range check and handshake live in the top module.

## Test plan
- **WAIT=1 read.** Preload word 5 with 0xDEADBEEF, drive `stb=1`, `we=0`, `adr=0x14` → `ack_o` rises on the 2nd falling edge after sampling, `dat_o=0xDEADBEEF` for one cycle, then `dat_o=0`.
- **Byte-lane write.** Word 3 = 0x11223344. Write `adr=0x0C`, `sel=4'b1001`, `dat_i=0xAABBCCDD`, then read back → 0xAA2233DD.
- **Out-of-range.** `AW=10`, `adr=0x0000_1000`, write → `err_o` pulses once, `ack_o` stays 0, and a read of word 0 is unchanged.
- **Abort.** `WAIT=3` write to word 7; drop `stb` after one wait cycle → no ack/err, word 7 unchanged, FSM back in IDLE.
- **Reset mid-WAIT.** `WAIT=3` write to word 9; assert `nrst` during WAIT → `ack_o=0` immediately, word 9 unchanged, and the next transfer completes normally.
- **WAIT=0 streaming.** Hold `stb` high for 4 consecutive reads → an ack every 2 cycles with the correct data each time.

Source files
------------

// File: rtl/aemb_wb_pkg.sv
// rtl/aemb_wb_pkg.sv - shared FSM encodings, lane constants and request type for the AEMB data-bus SRAM
package aemb_wb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Big-endian lanes: lane 0 is the lowest byte address and sits in the top byte.
    localparam int LANE0_HI = 31;
    localparam int LANE1_HI = 23;
    localparam int LANE2_HI = 15;
    localparam int LANE3_HI = 7;

    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 15;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wb_req_t;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] m;
        m = old_w;
        if (sel[3]) m[LANE0_HI -: 8] = new_w[LANE0_HI -: 8];
        if (sel[2]) m[LANE1_HI -: 8] = new_w[LANE1_HI -: 8];
        if (sel[1]) m[LANE2_HI -: 8] = new_w[LANE2_HI -: 8];
        if (sel[0]) m[LANE3_HI -: 8] = new_w[LANE3_HI -: 8];
        return m;
    endfunction

endpackage

// File: rtl/aemb_dwb_sram_if.sv
// rtl/aemb_dwb_sram_if.sv - Wishbone data-bus signal bundle between the AEMB core and its SRAM
interface aemb_dwb_sram_if;

    logic        dwb_stb_i;
    logic        dwb_we_i;
    logic [31:0] dwb_adr_i;
    logic [3:0]  dwb_sel_i;
    logic [31:0] dwb_dat_i;
    logic [31:0] dwb_dat_o;
    logic        dwb_ack_o;
    logic        dwb_err_o;

    modport master (
        output dwb_stb_i, dwb_we_i, dwb_adr_i, dwb_sel_i, dwb_dat_i,
        input  dwb_dat_o, dwb_ack_o, dwb_err_o
    );

    modport slave (
        input  dwb_stb_i, dwb_we_i, dwb_adr_i, dwb_sel_i, dwb_dat_i,
        output dwb_dat_o, dwb_ack_o, dwb_err_o
    );

endinterface

// File: rtl/aemb_wb_sram_core.sv
// rtl/aemb_wb_sram_core.sv - 2^AW x 32 word array with byte-lane writes and a registered read port
module aemb_wb_sram_core
    import aemb_wb_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          nclk,
    input  logic          nrst,
    input  logic          rd_en_i,
    input  logic [3:0]    wbe_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [0:(1<<AW)-1];
    logic [31:0] rdata_q;

    // Array contents are deliberately outside the reset domain.
    always_ff @(negedge nclk) begin
        if (|wbe_i) begin
            mem_q[addr_i] <= lane_merge(mem_q[addr_i], wdata_i, wbe_i);
        end
    end

    always_ff @(negedge nclk or posedge nrst) begin
        if (nrst) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/aemb_dwb_sram.sv
// rtl/aemb_dwb_sram.sv - Wishbone SRAM responder: request capture, wait-state FSM, range check, ack/err
module aemb_dwb_sram
    import aemb_wb_pkg::*;
#(
    parameter int AW   = 10,
    parameter int WAIT = 1
) (
    input  logic            nclk,
    input  logic            nrst,
    aemb_dwb_sram_if.slave  dwb
);

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

    if (WAIT < 0 || WAIT > WAIT_MAX) begin : g_bad_wait
        $error("aemb_dwb_sram: WAIT must be within 0..15");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    adr_q, adr_d;
    wb_req_t          req_q, req_d;
    logic             rerr_q, rerr_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic             live_err;
    logic             commit;
    logic [AW-1:0]    c_adr;
    wb_req_t          c_req;
    logic             c_err;

    assign live_err = |(dwb.dwb_adr_i >> (AW + 2));

    // c_* is the request acted on at the commit edge: live bus in IDLE, captured copy in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        req_d   = req_q;
        rerr_d  = rerr_q;
        commit  = 1'b0;
        c_adr   = adr_q;
        c_req   = req_q;
        c_err   = rerr_q;
        case (state_q)
            ST_IDLE: begin
                if (dwb.dwb_stb_i) begin
                    adr_d     = dwb.dwb_adr_i[AW+1:2];
                    req_d.we  = dwb.dwb_we_i;
                    req_d.sel = dwb.dwb_sel_i;
                    req_d.dat = dwb.dwb_dat_i;
                    rerr_d    = live_err;
                    cnt_d     = WAIT_CNT;
                    c_adr     = adr_d;
                    c_req     = req_d;
                    c_err     = rerr_d;
                    if (WAIT_CNT == '0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!dwb.dwb_stb_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ack_d = commit & ~c_err;
        err_d = commit & c_err;
    end

    always_ff @(negedge nclk or posedge nrst) begin
        if (nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            req_q   <= '0;
            rerr_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            req_q   <= req_d;
            rerr_q  <= rerr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    aemb_wb_sram_core #(.AW(AW)) u_core (
        .nclk    (nclk),
        .nrst    (nrst),
        .rd_en_i (ack_d & ~c_req.we),
        .wbe_i   ((ack_d & c_req.we) ? c_req.sel : 4'b0000),
        .addr_i  (c_adr),
        .wdata_i (c_req.dat),
        .rdata_o (dwb.dwb_dat_o)
    );

    assign dwb.dwb_ack_o = ack_q;
    assign dwb.dwb_err_o = err_q;

endmodule
